// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set, non-excluded req bit
// scanning upward from start, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    input  logic [N-1:0]    excl,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int p;
        p     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            p = int'(start) + k;
            if (p >= N) p = p - N;
            if (!found && req[p] && !excl[p]) begin
                found = 1'b1;
                idx   = ID_W'(p);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// N-way round-robin arbiter with registered one-hot grants held while requested.
// Optional hold-timeout preemption is enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               preempt
);

    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ ||
        MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
        $error("rr_grant_arbiter: illegal NUM_REQ/MAX_HOLD");
    end

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [ID_W-1:0]    id_n;
    logic [ID_W-1:0]    ptr, ptr_n;
    logic               busy_n;
    logic               pre_n;
    logic               own_req;
    logic [NUM_REQ-1:0] excl;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;

    // While granted, ptr == owner+1, so one pick serves both paths.
    assign own_req = |(req & gnt);
    assign excl    = (state == GRANT) ? gnt : '0;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req   (req),
        .start (ptr),
        .excl  (excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    logic [7:0] hold, hold_n;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        id_n    = gnt_id;
        ptr_n   = ptr;
        busy_n  = busy;
        pre_n   = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_n  = hold;
`endif
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!own_req && !pick_found) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    id_n    = '0;
                    busy_n  = 1'b0;
                end
`ifdef ARB_HOLD_TIMEOUT_EN
                else if (own_req && hold == HOLD_MAX && pick_found) begin
                    pre_n = 1'b1;
                end else if (own_req && hold != HOLD_MAX) begin
                    hold_n = hold + 8'd1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
        // A new owner is taken from idle, on a drop, or on a timeout.
        if (pick_found && (state == IDLE || !own_req || pre_n)) begin
            state_n        = GRANT;
            gnt_n          = '0;
            gnt_n[pick_idx] = 1'b1;
            id_n           = pick_idx;
            busy_n         = 1'b1;
            ptr_n          = (pick_idx == ID_W'(NUM_REQ - 1)) ?
                             '0 : pick_idx + 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_n         = 8'd1;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            ptr     <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold    <= '0;
`endif
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_id  <= id_n;
            ptr     <= ptr_n;
            busy    <= busy_n;
            preempt <= pre_n;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold    <= hold_n;
`endif
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios plus
// random requests against an owner/pointer reference model.
module tb_rr_grant_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clock;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         preempt;

    int total = 0;
    int bad   = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_pre   = 0;

    rr_grant_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int pick(logic [N-1:0] r, int s, int ex);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (s + k) % N;
            if (r[i] && i != ex) return i;
        end
        return -1;
    endfunction

    function automatic void take(int p);
        m_owner = p;
        m_ptr   = (p + 1) % N;
        m_hold  = 1;
    endfunction

    function automatic void model_edge(logic [N-1:0] r, bit rst);
        int p;
        m_pre = 0;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            return;
        end
        if (m_owner < 0) begin
            p = pick(r, m_ptr, -1);
            if (p >= 0) take(p);
        end else if (!r[m_owner]) begin
            p = pick(r, (m_owner + 1) % N, m_owner);
            if (p >= 0) take(p);
            else m_owner = -1;
        end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
            p = pick(r, (m_owner + 1) % N, m_owner);
            if (m_hold >= MH && p >= 0) begin
                take(p);
                m_pre = 1;
            end else if (m_hold < MH) begin
                m_hold++;
            end
`endif
        end
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(logic [N-1:0] r, bit rst);
        logic [N-1:0] eg;
        req   = r;
        reset = rst;
        @(posedge clock);
        model_edge(r, rst);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("gnt",     32'(gnt),     32'(eg));
        check("gnt_id",  32'(gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("busy",    32'(busy),    32'(m_owner >= 0));
        check("preempt", 32'(preempt), 32'(m_pre));
    endtask

    initial begin
        req   = '0;
        reset = 1'b1;

        // reset and first grant
        cyc(4'b0000, 1);
        cyc(4'b0000, 1);
        check("rst_gnt", 32'(gnt), 32'd0);
        cyc(4'b0000, 0);
        cyc(4'b0100, 0);
        check("first_gnt", 32'(gnt), 32'h4);
        check("first_id", 32'(gnt_id), 32'd2);

        // rotation 0,1,2,3,0 with direct handoff
        cyc(4'b0000, 1);
        cyc(4'b1111, 0);
        for (int g = 0; g < 5; g++) begin
            logic [N-1:0] r;
            cyc(4'b1111, 0);
            cyc(4'b1111, 0);
            check("rot_id", 32'(gnt_id), 32'(g % 4));
            r = 4'b1111;
            r[g % 4] = 1'b0;
            cyc(r, 0);
            check("rot_busy", 32'(busy), 32'd1);
        end

        // wrap and exclude
        cyc(4'b0000, 1);
        cyc(4'b1000, 0);
        cyc(4'b1001, 0);
        check("wrap_own", 32'(gnt), 32'h8);
        cyc(4'b0001, 0);
        check("wrap_gnt", 32'(gnt), 32'h1);
        cyc(4'b1010, 0);
        check("wrap_next", 32'(gnt), 32'h2);

        // idle return and regrant
        cyc(4'b0000, 1);
        cyc(4'b0010, 0);
        cyc(4'b0000, 0);
        check("idle_gnt", 32'(gnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        cyc(4'b0010, 0);
        check("regrant", 32'(gnt), 32'h2);

        // reset mid-grant
        cyc(4'b0011, 1);
        check("midrst", 32'(gnt), 32'd0);
        cyc(4'b0011, 0);
        check("midrst_next", 32'(gnt), 32'h1);

        // long hold by owner 0 with a competitor, then alone
        for (int i = 0; i < 12; i++) cyc(4'b0011, 0);
        cyc(4'b0000, 1);
        for (int i = 0; i < 12; i++) cyc(4'b0001, 0);
        check("solo_keep", 32'(gnt), 32'h1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if ($urandom_range(0, 3) != 0 && m_owner >= 0) r[m_owner] = 1'b1;
            cyc(r, $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
